// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared definitions for the digit-serial subtractor: FSM state
//               encoding, digit-counter width helper and the operand/digit
//               width legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // FSM state encoding (explicit 2-bit width, legacy-compatible constants)
    typedef logic [1:0] sub_state_t;

    localparam sub_state_t c_IDLE = 2'd0;
    localparam sub_state_t c_RUN  = 2'd1;
    localparam sub_state_t c_DONE = 2'd2;

    // Width of the digit counter; at least one bit so that a single-digit
    // configuration still has a legal (constant-zero) counter.
    function automatic int cnt_width(input int num_digits);
        return (num_digits <= 1) ? 1 : $clog2(num_digits);
    endfunction

    // A digit width is legal when it is non-zero and evenly tiles the operand.
    function automatic bit digit_width_ok(input int data_width, input int digit_width);
        return (digit_width > 0) && (digit_width <= data_width) &&
               ((data_width % digit_width) == 0);
    endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_digit.sv
`default_nettype none
// ============================================================================
// Module      : digit_subtractor
// Description : Combinational DIGIT_WIDTH-bit subtractor built from a ripple
//               of per-bit full-subtractor cells: diff = a - b - bin.
// Ports       : a, b   - digit operands
//               bin    - borrow in from the less significant digit
//               diff   - digit difference
//               bout   - borrow out of the most significant bit
// Revision    : 1.0 - initial release
// ============================================================================
module digit_subtractor #(
    parameter int DIGIT_WIDTH = 4
) (
    input  logic [DIGIT_WIDTH-1:0] a,
    input  logic [DIGIT_WIDTH-1:0] b,
    input  logic                   bin,
    output logic [DIGIT_WIDTH-1:0] diff,
    output logic                   bout
);

    // w_borrow[i] is the borrow entering bit i
    logic [DIGIT_WIDTH:0] w_borrow;

    assign w_borrow[0] = bin;

    for (genvar gi = 0; gi < DIGIT_WIDTH; gi++) begin : g_bit
        // Full subtractor: a borrow is generated when b exceeds a, and an
        // incoming borrow passes through when a and b are equal.
        assign diff[gi]         = a[gi] ^ b[gi] ^ w_borrow[gi];
        assign w_borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & w_borrow[gi]);
    end

    assign bout = w_borrow[DIGIT_WIDTH];

endmodule : digit_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle digit-serial unsigned subtractor. Computes
//               (A - B) mod 2^DATA_WIDTH, DIGIT_WIDTH bits per cycle, least
//               significant digit first, with a registered borrow between
//               digits. Valid/ready handshake on both sides.
// Ports       : clk, resetn          - clock, synchronous active-low reset
//               in_valid / in_ready  - operand handshake (ready only in IDLE)
//               in_sub_a, in_sub_b   - minuend / subtrahend (unsigned)
//               out_valid/out_ready  - result handshake (valid only in DONE)
//               out_diff_result      - (A - B) mod 2^DATA_WIDTH
//               out_borrow           - 1 when A < B
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sub_a,
    input  logic [DATA_WIDTH-1:0] in_sub_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_diff_result,
    output logic                  out_borrow
);

    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CNT_W      = cnt_width(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    if (!digit_width_ok(DATA_WIDTH, DIGIT_WIDTH)) begin : g_bad_digit_width
        $error("serial_subtractor: DIGIT_WIDTH (%0d) must divide DATA_WIDTH (%0d)",
               DIGIT_WIDTH, DATA_WIDTH);
    end

    sub_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_b;
    logic [DATA_WIDTH-1:0]  r_diff;
    logic                   r_borrow;      // inter-digit borrow chain
    logic                   r_borrow_out;  // final borrow, held for output

    logic [DIGIT_WIDTH-1:0] w_a_dig;
    logic [DIGIT_WIDTH-1:0] w_b_dig;
    logic [DIGIT_WIDTH-1:0] w_dig_diff;
    logic                   w_dig_bout;

    // Select the operand digits addressed by the counter
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_dig = r_a[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                w_b_dig = r_b[k*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    digit_subtractor #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_digit_subtractor (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .bin  (r_borrow),
        .diff (w_dig_diff),
        .bout (w_dig_bout)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // in_ready is implied by being in IDLE
                    if (in_valid) begin
                        r_a      <= in_sub_a;
                        r_b      <= in_sub_b;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_diff[k*DIGIT_WIDTH +: DIGIT_WIDTH] <= w_dig_diff;
                        end
                    end
                    r_borrow <= w_dig_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_DIGIT) begin
                        r_borrow_out <= w_dig_bout;
                        r_state      <= c_DONE;
                    end
                end
                c_DONE: begin
                    // Result registers are left untouched so they stay
                    // readable until the next computation overwrites them.
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (r_state == c_IDLE);
    assign out_valid       = (r_state == c_DONE);
    assign out_diff_result = r_diff;
    assign out_borrow      = r_borrow_out;

endmodule : serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle digit-serial unsigned subtractor; the inverse counterpart to the team's registered ripple-carry adder.
- Computes A - B mod 2^DATA_WIDTH, DIGIT_WIDTH bits per cycle, with a registered borrow chain between digits.
- Valid/ready handshake on input and output; sits in the GF/integer arithmetic datapath next to the adder blocks.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits.
- DIGIT_WIDTH, 4, bits processed per cycle; must divide DATA_WIDTH (elaboration error otherwise).
- NUM_DIGITS, DATA_WIDTH/DIGIT_WIDTH, derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_sub_a  in  DATA_WIDTH  minuend A, unsigned.
- in_sub_b  in  DATA_WIDTH  subtrahend B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_diff_result  out  DATA_WIDTH  (A - B) mod 2^DATA_WIDTH.
- out_borrow  out  1  1 when A < B (unsigned).

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. While resetn=0 at a rising edge:
  - state goes to IDLE.
  - out_valid=0, out_diff_result=0, out_borrow=0.
  - digit counter=0, borrow register=0, operand registers=0.
  - in_ready=1 from the first cycle after reset.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE), decoded from the registered state only. out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid && in_ready at an edge: capture A and B, clear counter and borrow, go to RUN.
  - Operand inputs are ignored at all other times.
- RUN:
  - Each edge processes digit k=counter, bits [k*DIGIT_WIDTH +: DIGIT_WIDTH].
  - diff_k = A_k - B_k - borrow. The new borrow is the borrow-out of that digit.
  - diff_k is written into the result register at digit k; counter increments.
  - The edge that processes digit NUM_DIGITS-1 also loads out_borrow with the final borrow and moves to DONE.
- Latency:
  - Acceptance edge E0; digits are processed on edges E1..E(NUM_DIGITS).
  - out_valid is high in the cycle after E(NUM_DIGITS), i.e. NUM_DIGITS cycles after acceptance (8 for defaults).
- DONE:
  - out_valid=1; out_diff_result and out_borrow stay stable until out_ready.
  - On out_valid && out_ready at an edge: go to IDLE, out_valid=0.
  - Result and borrow registers keep their values until the next computation overwrites them.
- Throughput: one operation per NUM_DIGITS+2 cycles minimum. No overlap of accept and deliver; in_ready=0 in DONE even if out_ready=1.
- in_valid during RUN/DONE is ignored; the upstream holds it per the valid/ready rule.
- Boundaries:
  - A==B gives 0 with borrow 0.
  - A=0, B=max gives 1 with borrow 1.
  - The borrow must propagate across all digit boundaries, so full-chain cases such as 0 - 1 must give all-ones.
  - Reset asserted in RUN or DONE aborts: no out_valid, outputs zeroed, state IDLE.
- DIGIT_WIDTH==DATA_WIDTH is legal: NUM_DIGITS=1, out_valid one cycle after acceptance.

Decomposition:
- Shared arithmetic package: FSM state enum (IDLE/RUN/DONE), counter-width helper clog2(NUM_DIGITS), and the DIGIT_WIDTH-divides-DATA_WIDTH check macro/function.
- Sub-module digit_subtractor (DIGIT_WIDTH):
  - Combinational ripple of per-bit full-subtractor cells.
  - Inputs a, b, bin; outputs diff, bout.
  - One instance in serial_subtractor.

Test Plan:
- Reset then 0x0000_000A - 0x0000_0003 -> out_valid exactly 8 cycles after acceptance, out_diff_result=0x0000_0007, out_borrow=0, in_ready=0 throughout RUN/DONE.
- 0x0000_0000 - 0x0000_0001 -> out_diff_result=0xFFFF_FFFF, out_borrow=1 (borrow crosses all 8 digits).
- 0x1234_5678 - 0x1234_5678 -> 0x0000_0000, borrow 0. Then 0x8000_0000 - 0x0000_0001 -> 0x7FFF_FFFF, borrow 0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable. in_valid with new operands is not accepted until one cycle after the out handshake, and the next result corresponds to the new operands.
- resetn=0 at the 4th RUN cycle -> next cycle out_valid=0, out_diff_result=0, in_ready=1. A fresh 5 - 9 -> 0xFFFF_FFFC, borrow 1.
- Random regression (1000 ops, random out_ready/in_valid gaps, DIGIT_WIDTH in {1,4,8,32}) against a reference model (A-B) mod 2^32 and borrow (A<B).
